seq_detector_1101: RTL and testbench
====================================

SEQ_DETECTOR_1101 -- requirements
Module: seq_detector_1101

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, reset, synchronous and active-low.
REQ-003 The block SHALL have the port `din`: input, 1 bit, the serial data bit, sampled on the rising edge of `clk`; it is driven by the upstream flip-flop Q output.
REQ-004 The block SHALL have the port `en`: input, 1 bit, sample enable; when low, `din` is ignored and all state holds.
REQ-005 The block SHALL have the port `clr`: input, 1 bit, synchronous clear of the match counter only.
REQ-006 The block SHALL have the port `detect`: output, 1 bit, high while the FSM is in the MATCH state (Moore output).
REQ-007 The block SHALL have the port `count`: output, 4 bits, the number of matches since reset or clear, saturating.
REQ-008 The block SHALL have the port `state`: output, 3 bits, the current FSM state encoding, for debug and verification.

Function
REQ-009 The block SHALL detect the serial pattern 1,1,0,1 (first-received bit first), with overlapping matches allowed.
REQ-010 The block SHALL implement a Moore FSM with states and encodings IDLE=000, S1=001, S11=010, S110=011, MATCH=100.
REQ-011 Transitions SHALL apply only on a rising edge with en=1; state changes SHALL be to the right of the arrow for the given din value:
- IDLE: din=1 -> S1; din=0 -> IDLE.
- S1: din=1 -> S11; din=0 -> IDLE.
- S11: din=1 -> S11; din=0 -> S110.
- S110: din=1 -> MATCH; din=0 -> IDLE.
- MATCH: din=1 -> S11 (overlap); din=0 -> IDLE.
REQ-012 Encodings 101, 110 and 111 SHALL never be reached; if one is ever present, the next clock edge SHALL force IDLE regardless of en.
REQ-013 `detect` SHALL be 1 exactly when state=MATCH and SHALL be decoded from state only, with no dependence on din.
REQ-014 Latency: `detect` SHALL rise on the edge that samples the fourth pattern bit and stay high for one enabled cycle (longer if en drops while in MATCH).
REQ-015 `count` SHALL increment by 1 on each edge where the next state is MATCH and the current state is not MATCH, given en=1.
REQ-016 `count` SHALL saturate at 15 (4'hF) with no wrap to 0.
REQ-017 With en=0, state and count SHALL hold; clr SHALL still act.
REQ-018 When clr=1, count SHALL become 0 on the next edge; clr SHALL have priority over a simultaneous increment, and the FSM SHALL still advance normally.
REQ-019 All state elements SHALL be edge-triggered on rising clk; there SHALL be no latches or asynchronous paths.

Reset
REQ-020 When rst=0 at a rising edge, the block SHALL set state=IDLE (000), count=0 and detect=0 on that edge, overriding en, clr and din.
REQ-021 A reset asserted mid-pattern (e.g. in S110) SHALL discard the partial match; the bits received before reset SHALL NOT contribute to a later match.
REQ-022 After rst returns to 1, the first edge with en=1 SHALL evaluate din from IDLE.

Verification
REQ-023 The bench SHALL cover this scenario: reset, then en=1 and din stream 1,1,0,1 -> detect=1 after the 4th edge, state=100, count=1; next din=0 -> detect=0, state=000.
REQ-024 The bench SHALL cover this scenario: din stream 1,1,0,1,1,0,1 -> detect high after edges 4 and 7, count=2 (overlap through MATCH->S11).
REQ-025 The bench SHALL cover this scenario: din stream 1,1,1,1,0,1 -> single match after edge 6, count=1, with state passing 001,010,010,010,011,100.
REQ-026 The bench SHALL cover this scenario: en=0 for 3 cycles while in S110 with din toggling -> state stays 011; then en=1 with din=1 -> MATCH, count increments.
REQ-027 The bench SHALL cover this scenario: 17 back-to-back matches -> count stops at 15; then clr=1 on the same edge as a match -> count=0 and detect=1.
REQ-028 The bench SHALL cover this scenario: rst=0 asserted while in S110 -> state=000, count=0; then din=1 -> state=001, with no spurious match.

Source files
------------

// File: rtl/seq_detector_1101.sv
// Serial 1101 detector with overlap: Moore FSM, detect rises on the edge sampling the 4th bit.
// Saturating 4-bit match counter with synchronous clear; en low freezes FSM and counter.
module seq_detector_1101 (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   input  logic       en,
   input  logic       clr,
   output logic       detect,
   output logic [3:0] count,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      S1    = 3'b001,
      S11   = 3'b010,
      S110  = 3'b011,
      MATCH = 3'b100
   } state_e;

   state_e     state_q, state_d;
   logic [3:0] count_q, count_d;
   logic       inc_match;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = din ? S1    : IDLE;
         S1:      if (en) state_d = din ? S11   : IDLE;
         S11:     if (en) state_d = din ? S11   : S110;
         S110:    if (en) state_d = din ? MATCH : IDLE;
         MATCH:   if (en) state_d = din ? S11   : IDLE;
         // unused encodings recover to IDLE even while en is low
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      inc_match = en && (state_d == MATCH) && (state_q != MATCH);
      if (clr) begin
         count_d = 4'd0;
      end else if (inc_match && (count_q != 4'hF)) begin
         count_d = count_q + 4'd1;
      end
   end

   assign detect = (state_q == MATCH);
   assign count  = count_q;
   assign state  = state_q;

endmodule

// File: tb/tb_seq_detector_1101.sv
// Directed self-checking bench for seq_detector_1101; expectations are hand-computed constants.
module tb_seq_detector_1101;

   logic       clk;
   logic       rst;
   logic       din;
   logic       en;
   logic       clr;
   logic       detect;
   logic [3:0] count;
   logic [2:0] state;

   int n_cmp = 0;
   int n_err = 0;

   seq_detector_1101 dut (
      .clk    (clk),
      .rst    (rst),
      .din    (din),
      .en     (en),
      .clr    (clr),
      .detect (detect),
      .count  (count),
      .state  (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic d, input logic e, input logic c, input logic r);
      din = d;
      en  = e;
      clr = c;
      rst = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] cnt, input logic det);
      chk({tag, ".state"},  {1'b0, state}, {1'b0, st});
      chk({tag, ".count"},  count, cnt);
      chk({tag, ".detect"}, {3'b000, detect}, {3'b000, det});
   endtask

   initial begin
      din = 1'b0; en = 1'b0; clr = 1'b0; rst = 1'b0;

      // reset
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk_all("reset", 3'b000, 4'd0, 1'b0);

      // basic 1101
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("basic.e1", 3'b001, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("basic.e2", 3'b010, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("basic.e3", 3'b011, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("basic.e4", 3'b100, 4'd1, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("basic.e5", 3'b000, 4'd1, 1'b0);

      // clear while disabled: count clears, state holds
      step(1'b1, 1'b0, 1'b1, 1'b1); chk_all("clr_en0", 3'b000, 4'd0, 1'b0);

      // overlap 1101101
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("ovl.e1", 3'b001, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("ovl.e2", 3'b010, 4'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("ovl.e3", 3'b011, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("ovl.e4", 3'b100, 4'd1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("ovl.e5", 3'b010, 4'd1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("ovl.e6", 3'b011, 4'd1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("ovl.e7", 3'b100, 4'd2, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("ovl.idle", 3'b000, 4'd2, 1'b0);

      // 111101: single match
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("run.e1", 3'b001, 4'd2, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("run.e2", 3'b010, 4'd2, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("run.e3", 3'b010, 4'd2, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("run.e4", 3'b010, 4'd2, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("run.e5", 3'b011, 4'd2, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("run.e6", 3'b100, 4'd3, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("run.idle", 3'b000, 4'd3, 1'b0);

      // enable hold in S110, then in MATCH
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("hold.s110", 3'b011, 4'd3, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1); chk_all("hold.c1", 3'b011, 4'd3, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1); chk_all("hold.c2", 3'b011, 4'd3, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1); chk_all("hold.c3", 3'b011, 4'd3, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("hold.match", 3'b100, 4'd4, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1); chk_all("hold.inmatch", 3'b100, 4'd4, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("hold.idle", 3'b000, 4'd4, 1'b0);

      // saturation: 17 back-to-back overlapping matches
      step(1'b0, 1'b1, 1'b1, 1'b1); chk_all("sat.clr", 3'b000, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("sat.m1", 3'b100, 4'd1, 1'b1);
      for (int k = 2; k <= 17; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1);
         step(1'b0, 1'b1, 1'b0, 1'b1);
         step(1'b1, 1'b1, 1'b0, 1'b1);
         chk_all($sformatf("sat.m%0d", k), 3'b100, (k > 15) ? 4'hF : 4'(k), 1'b1);
      end

      // clear wins over a simultaneous increment
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1); chk_all("clr_match", 3'b100, 4'd0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("clr_after", 3'b000, 4'd0, 1'b0);

      // reset mid-pattern discards partial match
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("rst.pre_m", 3'b100, 4'd1, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1); chk_all("rst.s110", 3'b011, 4'd1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0); chk_all("rst.asserted", 3'b000, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("rst.post1", 3'b001, 4'd0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1); chk_all("rst.post2", 3'b010, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
